instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the decode/control unit. Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Buffers returned words in a small FIFO and presents instruction, PC and the split opcode/funct3/funct7/register fields to decode with a valid/ready handshake. Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, base opcodes, canonical NOP and the
// fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// The head is presented combinationally and reads as zero when empty.
module fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            pop,
    input  logic            flush,
    output logic            valid,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_instr,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN+31:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_push = push && !flush && (count != DEPTH_C);
    assign do_pop  = pop && !flush && valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_pc, push_instr};
    end

    always_comb begin
        head_pc    = '0;
        head_instr = '0;
        if (valid) {head_pc, head_instr} = mem[rd_ptr];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word fetch at a time over req/gnt/rvalid, buffers
// responses in fetch_fifo and hands them to decode; redirects flush the stream.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            instr_ready,
    output logic            instr_valid,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);
    import riscv_pkg::*;

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] tag;
    logic            discard;
    logic            push;
    logic            pop;
    logic            gnt_now;
    logic            rsp_now;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_after;
    logic            space;
    logic            unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    assign gnt_now = (state == FETCH_REQ) && imem_gnt;
    assign rsp_now = (state == FETCH_WAIT) && imem_rvalid;
    assign push    = rsp_now && !discard && !redirect_valid;
    assign pop     = instr_valid && instr_ready;

    // Space is judged on the occupancy the FIFO will hold after this edge.
    always_comb begin
        count_after = count;
        if (redirect_valid) begin
            count_after = '0;
        end else begin
            if (push) count_after = count_after + CW'(1);
            if (pop)  count_after = count_after - CW'(1);
        end
    end

    assign space = (count_after < DEPTH_C);

    // A grant for a stale (discarded) request must not advance the new stream.
    always_comb begin
        pc_next = fetch_pc;
        if (redirect_valid)
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        else if (gnt_now && !discard)
            pc_next = fetch_pc + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            fetch_pc  <= RESET_PC;
            discard   <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            fetch_pc <= pc_next;
            case (state)
                FETCH_IDLE: begin
                    if (space) begin
                        state     <= FETCH_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_next;
                    end
                end
                FETCH_REQ: begin
                    if (redirect_valid) discard <= 1'b1;
                    if (imem_gnt) begin
                        state    <= FETCH_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (space) begin
                            state     <= FETCH_REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_next;
                        end else begin
                            state <= FETCH_IDLE;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_now) tag <= imem_addr;
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_pc    (tag),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (redirect_valid),
        .valid      (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr_data),
        .count      (count)
    );

    assign opcode = instr_data[6:0];
    assign rd     = instr_data[11:7];
    assign funct3 = instr_data[14:12];
    assign rs1    = instr_data[19:15];
    assign rs2    = instr_data[24:20];
    assign funct7 = instr_data[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the bench plays instruction memory and
// decode, stepping the handshake cycle by cycle against hand-computed values.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int passed = 0;
    int total  = 0;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", imem_addr); else passed++;
        total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", instr_valid); else passed++;
        total++; if (instr_data !== 32'h0) $display("FAIL rst_data: got %h want 00000000", instr_data); else passed++;
        total++; if (instr_pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", instr_pc); else passed++;
        total++; if ({opcode, funct3, funct7, rd, rs1, rs2} !== 32'h0) $display("FAIL rst_fields: got %h want 0", {opcode, funct3, funct7, rd, rs1, rs2}); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req: got req=%0h addr=%h want req=1 addr=00000000", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_basic_fetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL basic_wait: got valid=%0h req=%0h want 0 0", instr_valid, imem_req); else passed++;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b1) $display("FAIL basic_valid: got %0h want 1", instr_valid); else passed++;
        total++; if (instr_pc !== 32'h0) $display("FAIL basic_pc: got %h want 00000000", instr_pc); else passed++;
        total++; if (instr_data !== 32'h0050_0093) $display("FAIL basic_data: got %h want 00500093", instr_data); else passed++;
        total++; if (opcode !== OP_IMM || rd !== 5'd1 || funct3 !== 3'd0 || rs1 !== 5'd0 || rs2 !== 5'd5 || funct7 !== 7'd0)
            $display("FAIL basic_fields: got op=%b rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%0d want op=0010011 rd=1 f3=0 rs1=0 rs2=5 f7=0", opcode, rd, funct3, rs1, rs2, funct7); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL basic_next: got req=%0h addr=%h want req=1 addr=00000004", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_fifo_full();
        int req_seen;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0113;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hFFFF_FFFF;
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req !== 1'b0) req_seen++;
            tick();
        end
        total++; if (req_seen != 0) $display("FAIL full_req_low: got %0d request cycles want 0", req_seen); else passed++;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL full_head: got valid=%0h pc=%h want 1 00000000", instr_valid, instr_pc); else passed++;
        instr_ready = 1'b1;
        tick();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_data !== 32'h00A0_0113 || rd !== 5'd2)
            $display("FAIL full_pop1: got valid=%0h pc=%h data=%h rd=%0d want 1 00000004 00a00113 2", instr_valid, instr_pc, instr_data, rd); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL full_refill: got req=%0h addr=%h want 1 00000008", imem_req, imem_addr); else passed++;
        tick();
        instr_ready = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL full_empty: got valid=%0h data=%h pc=%h want 0 0 0", instr_valid, instr_data, instr_pc); else passed++;
    endtask

    task automatic test_gnt_stall();
        int unstable;
        unstable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) unstable++;
        end
        total++; if (unstable != 0) $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_81B3;
        total++; if (imem_req !== 1'b0) $display("FAIL stall_granted: got req=%0h want 0", imem_req); else passed++;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_pc !== 32'h8 || opcode !== OP_R || rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2)
            $display("FAIL stall_instr: got pc=%h op=%b rd=%0d rs1=%0d rs2=%0d want 00000008 0110011 3 1 2", instr_pc, opcode, rd, rs1, rs2); else passed++;
        total++; if (imem_addr !== 32'hC) $display("FAIL stall_next_addr: got %h want 0000000c", imem_addr); else passed++;
        instr_ready = 1'b1;
        imem_gnt    = 1'b1;
        tick();
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL stall_pop_wait: got valid=%0h req=%0h want 0 0", instr_valid, imem_req); else passed++;
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rdw_hold: got valid=%0h req=%0h want 0 0", instr_valid, imem_req); else passed++;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b0) $display("FAIL rdw_dropped: got valid=%0h pc=%h want valid 0", instr_valid, instr_pc); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rdw_new_addr: got req=%0h addr=%h want 1 00000100", imem_req, imem_addr); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4020_8233;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || funct7 !== 7'b0100000 || rd !== 5'd4)
            $display("FAIL rdw_first: got valid=%0h pc=%h f7=%b rd=%0d want 1 00000100 0100000 4", instr_valid, instr_pc, funct7, rd); else passed++;
        total++; if (imem_addr !== 32'h104) $display("FAIL rdw_seq: got %h want 00000104", imem_addr); else passed++;
    endtask

    task automatic test_redirect_coincident();
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        instr_ready    = 1'b1;
        tick();
        idle_inputs();
        total++; if (instr_valid !== 1'b0 || instr_data !== 32'h0) $display("FAIL coin_flush: got valid=%0h data=%h want 0 0", instr_valid, instr_data); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL coin_align: got req=%0h addr=%h want 1 00000200", imem_req, imem_addr); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = NOP_INSTR;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || opcode !== OP_IMM)
            $display("FAIL coin_first: got valid=%0h pc=%h op=%b want 1 00000200 0010011", instr_valid, instr_pc, opcode); else passed++;
    endtask

    task automatic test_stale_req_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h204 || instr_valid !== 1'b0)
            $display("FAIL stale_held: got req=%0h addr=%h valid=%0h want 1 00000204 0", imem_req, imem_addr, instr_valid); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL stale_drop: got valid=%0h addr=%h want 0 fffffffc", instr_valid, imem_addr); else passed++;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_pc !== 32'hFFFF_FFFC || opcode !== OP_JAL) $display("FAIL wrap_instr: got pc=%h op=%b want fffffffc 1101111", instr_pc, opcode); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr: got req=%0h addr=%h want 1 00000000", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || opcode !== 7'd0)
            $display("FAIL mid_rst_async: got req=%0h valid=%0h data=%h pc=%h want all 0", imem_req, instr_valid, instr_data, instr_pc); else passed++;
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL mid_rst_stray: got valid=%0h req=%0h addr=%h want 0 1 00000000", instr_valid, imem_req, imem_addr); else passed++;
        tick();
        total++; if (instr_valid !== 1'b0) $display("FAIL mid_rst_stray2: got valid=%0h want 0", instr_valid); else passed++;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'h0050_0093)
            $display("FAIL mid_rst_refetch: got valid=%0h pc=%h data=%h want 1 00000000 00500093", instr_valid, instr_pc, instr_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_fifo_full();
        test_gnt_stall();
        test_redirect_wait();
        test_redirect_coincident();
        test_stale_req_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
